// File: rtl/rs_multi_cdb.sv
// Reservation station for the ALU/branch path: buffers renamed ops, snoops CDB_NUM result buses
// and hands the oldest operand-complete op to the FU through a registered valid/ready stage.
module rs_multi_cdb #(
    parameter int RS_SIZE = 16,
    parameter int ROB_LOG = 4,
    parameter int OP_LOG  = 6,
    parameter int CDB_NUM = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rdy,
    input  logic                            jump_flag,
    input  logic                            issue_valid,
    output logic                            issue_ready,
    input  logic [OP_LOG-1:0]               issue_op,
    input  logic [31:0]                     issue_Vj,
    input  logic [31:0]                     issue_Vk,
    input  logic                            issue_Rj,
    input  logic                            issue_Rk,
    input  logic [ROB_LOG-1:0]              issue_Qj,
    input  logic [ROB_LOG-1:0]              issue_Qk,
    input  logic [31:0]                     issue_Imm,
    input  logic [ROB_LOG-1:0]              issue_DestRob,
    input  logic [31:0]                     issue_CurPC,
    input  logic [CDB_NUM-1:0]              cdb_valid,
    input  logic [CDB_NUM*ROB_LOG-1:0]      cdb_RobId,
    input  logic [CDB_NUM*32-1:0]           cdb_value,
    output logic                            FU_valid,
    input  logic                            FU_ready,
    output logic [OP_LOG-1:0]               FU_op,
    output logic [31:0]                     FU_Vj,
    output logic [31:0]                     FU_Vk,
    output logic [31:0]                     FU_Imm,
    output logic [ROB_LOG-1:0]              FU_DestRob,
    output logic [31:0]                     FU_CurPC,
    output logic [$clog2(RS_SIZE+1)-1:0]    RS_count
);

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = $clog2(RS_SIZE+1);

    typedef struct packed {
        logic        hit;
        logic [31:0] val;
    } snoop_t;

    // Control state (reset/flushed)
    logic [RS_SIZE-1:0] busy, rj, rk;
    logic [RS_SIZE-1:0] older    [RS_SIZE];   // older[j][i]: entry j is older than entry i
    logic [RS_SIZE-1:0] older_nx [RS_SIZE];

    // Entry payload (never reset)
    logic [OP_LOG-1:0]  e_op   [RS_SIZE];
    logic [31:0]        e_vj   [RS_SIZE];
    logic [31:0]        e_vk   [RS_SIZE];
    logic [31:0]        e_imm  [RS_SIZE];
    logic [31:0]        e_pc   [RS_SIZE];
    logic [ROB_LOG-1:0] e_qj   [RS_SIZE];
    logic [ROB_LOG-1:0] e_qk   [RS_SIZE];
    logic [ROB_LOG-1:0] e_dest [RS_SIZE];

    snoop_t             snp_j [RS_SIZE];
    snoop_t             snp_k [RS_SIZE];
    snoop_t             iss_sj, iss_sk;
    logic [RS_SIZE-1:0] wake_j, wake_k, cand, free_vec, alloc_vec;
    logic [IDX_W-1:0]   free_idx, sel_idx;
    logic               free_found, sel_found, blocked;
    logic               flush, load, issue_accept, dispatch;
    logic               iss_rj, iss_rk;
    logic [31:0]        iss_vj, iss_vk;

    // Lowest channel wins: scan high to low so the last hit assigned is the lowest index.
    function automatic snoop_t snoop(input logic [ROB_LOG-1:0] tag);
        snoop_t s;
        s = '0;
        for (int c = CDB_NUM-1; c >= 0; c--) begin
            if (cdb_valid[c] && cdb_RobId[c*ROB_LOG +: ROB_LOG] == tag) begin
                s.hit = 1'b1;
                s.val = cdb_value[c*32 +: 32];
            end
        end
        return s;
    endfunction

    assign flush        = rst || jump_flag;
    assign issue_ready  = RS_count < CNT_W'(RS_SIZE);
    assign load         = !FU_valid || FU_ready;
    assign issue_accept = rdy && !flush && issue_valid && issue_ready;
    assign dispatch     = rdy && !flush && load && sel_found;

    // Issue-time bypass of a result broadcast in the same cycle
    always_comb begin
        iss_sj = snoop(issue_Qj);
        iss_sk = snoop(issue_Qk);
        iss_rj = issue_Rj || iss_sj.hit;
        iss_rk = issue_Rk || iss_sk.hit;
        iss_vj = (!issue_Rj && iss_sj.hit) ? iss_sj.val : issue_Vj;
        iss_vk = (!issue_Rk && iss_sk.hit) ? iss_sk.val : issue_Vk;
    end

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            snp_j[i]  = snoop(e_qj[i]);
            snp_k[i]  = snoop(e_qk[i]);
            wake_j[i] = busy[i] && !rj[i] && snp_j[i].hit;
            wake_k[i] = busy[i] && !rk[i] && snp_k[i].hit;
        end
    end

    // NOTE: every variable written in always_comb gets a default before any conditional
    // assignment; otherwise the tool infers a latch to hold the old value.
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!busy[i] && !free_found) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
        end
    end

    // Oldest-ready select: a candidate with no older candidate
    always_comb begin
        cand      = busy & rj & rk;
        sel_idx   = '0;
        sel_found = 1'b0;
        blocked   = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < RS_SIZE; j++) begin
                if (cand[j] && older[j][i]) blocked = 1'b1;
            end
            if (cand[i] && !blocked && !sel_found) begin
                sel_idx   = IDX_W'(i);
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        free_vec  = '0;
        alloc_vec = '0;
        if (dispatch)     free_vec[sel_idx]   = 1'b1;
        if (issue_accept) alloc_vec[free_idx] = 1'b1;
    end

    // Freed entries drop out of the age order; a new entry is younger than everyone still busy
    always_comb begin
        older_nx = older;
        for (int i = 0; i < RS_SIZE; i++) begin
            for (int j = 0; j < RS_SIZE; j++) begin
                if (free_vec[i] || free_vec[j]) older_nx[i][j] = 1'b0;
            end
        end
        if (issue_accept) begin
            for (int j = 0; j < RS_SIZE; j++) begin
                older_nx[j][free_idx] = busy[j] && !free_vec[j];
            end
            older_nx[free_idx] = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (flush) begin
            busy     <= '0;
            rj       <= '0;
            rk       <= '0;
            FU_valid <= 1'b0;
            RS_count <= '0;
            for (int i = 0; i < RS_SIZE; i++) older[i] <= '0;
        end else if (rdy) begin
            busy  <= (busy & ~free_vec) | alloc_vec;
            rj    <= ((rj | wake_j) & ~alloc_vec) | (alloc_vec & {RS_SIZE{iss_rj}});
            rk    <= ((rk | wake_k) & ~alloc_vec) | (alloc_vec & {RS_SIZE{iss_rk}});
            older <= older_nx;
            if (load) FU_valid <= sel_found;
            RS_count <= RS_count + CNT_W'(issue_accept) - CNT_W'(dispatch);
        end
    end

    // NOTE: payload storage has no reset; it is only observed behind busy/FU_valid,
    // and leaving it unreset keeps the data array free of reset fan-out.
    always_ff @(posedge clk) begin
        if (rdy && !flush) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (wake_j[i]) e_vj[i] <= snp_j[i].val;
                if (wake_k[i]) e_vk[i] <= snp_k[i].val;
            end
            if (issue_accept) begin
                e_op[free_idx]   <= issue_op;
                e_vj[free_idx]   <= iss_vj;
                e_vk[free_idx]   <= iss_vk;
                e_qj[free_idx]   <= issue_Qj;
                e_qk[free_idx]   <= issue_Qk;
                e_imm[free_idx]  <= issue_Imm;
                e_dest[free_idx] <= issue_DestRob;
                e_pc[free_idx]   <= issue_CurPC;
            end
            if (dispatch) begin
                FU_op      <= e_op[sel_idx];
                FU_Vj      <= e_vj[sel_idx];
                FU_Vk      <= e_vk[sel_idx];
                FU_Imm     <= e_imm[sel_idx];
                FU_DestRob <= e_dest[sel_idx];
                FU_CurPC   <= e_pc[sel_idx];
            end
        end
    end

endmodule
